// File: rtl/fpu_seq_pkg.sv
// Shared types and sizing helpers for the FPU operand sequencer.
package fpu_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_URST,
        S_FETCH,
        S_LOAD,
        S_BEGIN,
        S_WAIT_ACK,
        S_WRITE,
        S_DONE
    } seq_state_e;

    // Flag positions in the result word, as offsets above the P-bit result field.
    localparam int unsigned RES_TO_OFS = 2;
    localparam int unsigned RES_OF_OFS = 1;
    localparam int unsigned RES_UF_OFS = 0;

    // Address width for a memory of 'depth' entries (at least one bit).
    function automatic int unsigned seq_addr_w(input int unsigned depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

    // Watchdog width: must hold both the reset-hold and the ACK-timeout limits.
    function automatic int unsigned seq_wd_w(input int unsigned timeout, input int unsigned rst_cyc);
        int unsigned m;
        m = (timeout > rst_cyc) ? timeout : rst_cyc;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/fpu_op_sequencer_if.sv
// Operand-memory, unit and result-memory signals of the FPU operand sequencer.
interface fpu_op_sequencer_if #(
    parameter int unsigned P  = 32,
    parameter int unsigned AW = 10
);
    logic [AW-1:0] OP_ADDR;
    logic [P-1:0]  OP_DATA;
    logic          DUT_RST;
    logic          DUT_BEGIN;
    logic [P-1:0]  DUT_T;
    logic          DUT_ACK;
    logic          DUT_OF;
    logic          DUT_UF;
    logic [P-1:0]  DUT_RESULT;
    logic          RES_WE;
    logic [AW-1:0] RES_ADDR;
    logic [P+2:0]  RES_DATA;

    // Sequencer side.
    modport master (
        output OP_ADDR, DUT_RST, DUT_BEGIN, DUT_T, RES_WE, RES_ADDR, RES_DATA,
        input  OP_DATA, DUT_ACK, DUT_OF, DUT_UF, DUT_RESULT
    );

    // Memories and unit under sequencing.
    modport slave (
        input  OP_ADDR, DUT_RST, DUT_BEGIN, DUT_T, RES_WE, RES_ADDR, RES_DATA,
        output OP_DATA, DUT_ACK, DUT_OF, DUT_UF, DUT_RESULT
    );
endinterface

// File: rtl/fpu_op_sequencer_watchdog.sv
// Cycle counter with synchronous clear, enable and a compare-to-limit expire flag.
module seq_watchdog #(
    parameter int unsigned W = 8
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic         expire_c
);
    logic [W-1:0] cnt;

    assign expire_c = (cnt == limit);

    // Count enabled cycles, holding at the limit so the counter never wraps.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !expire_c) begin
            cnt <= cnt + W'(1);
        end
    end
endmodule

// File: rtl/fpu_op_sequencer.sv
// BIST-style operand sequencer: feeds each stored operand to a single-operand FPU
// unit, waits for its ACK under a watchdog and writes {TO,OF,UF,RESULT} back.
module fpu_op_sequencer
    import fpu_seq_pkg::*;
#(
    parameter int unsigned P       = 32,
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned RST_CYC = 4,
    parameter int unsigned TIMEOUT = 1000,
    localparam int unsigned AW     = seq_addr_w(DEPTH),
    localparam int unsigned CW     = AW + 1
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                START,
    input  logic                ABORT,
    input  logic [CW-1:0]       N_OPS,
    fpu_op_sequencer_if.master  bus,
    output logic                BUSY,
    output logic                DONE,
    output logic                ABORTED,
    output logic [CW-1:0]       OF_CNT,
    output logic [CW-1:0]       UF_CNT,
    output logic [CW-1:0]       TO_CNT
);
    localparam int unsigned RW   = P + 3;
    localparam int unsigned WD_W = seq_wd_w(TIMEOUT, RST_CYC);
    localparam int unsigned TO_B = P + RES_TO_OFS;
    localparam int unsigned OF_B = P + RES_OF_OFS;
    localparam int unsigned UF_B = P + RES_UF_OFS;

    seq_state_e    state;
    logic [AW-1:0] idx;
    logic [CW-1:0] count;

    logic            wd_clr_c;
    logic            wd_en_c;
    logic            wd_exp_c;
    logic [WD_W-1:0] wd_limit_c;
    logic [CW-1:0]   n_clamp_c;
    logic            last_c;
    logic            abort_c;
    logic [RW-1:0]   ack_word_c;
    logic [RW-1:0]   to_word_c;

    // Watchdog runs only while holding the unit in reset or waiting for ACK.
    always_comb begin
        wd_en_c    = (state == S_URST) || (state == S_WAIT_ACK);
        wd_clr_c   = !wd_en_c;
        wd_limit_c = (state == S_URST) ? WD_W'(RST_CYC - 1) : WD_W'(TIMEOUT - 1);
    end

    // Run-control decodes: clamped operand count, last-operand and abort qualifiers.
    always_comb begin
        n_clamp_c = (N_OPS > CW'(DEPTH)) ? CW'(DEPTH) : N_OPS;
        last_c    = ((CW'(idx) + CW'(1)) == count);
        abort_c   = ABORT && (state != S_IDLE) && (state != S_DONE);
    end

    // Result words for an acknowledged and a timed-out operand.
    always_comb begin
        ack_word_c          = '0;
        ack_word_c[P-1:0]   = bus.DUT_RESULT;
        ack_word_c[OF_B]    = bus.DUT_OF;
        ack_word_c[UF_B]    = bus.DUT_UF;
        to_word_c           = '0;
        to_word_c[TO_B]     = 1'b1;
    end

    seq_watchdog #(
        .W (WD_W)
    ) u_wd (
        .CLK      (CLK),
        .RST      (RST),
        .clr      (wd_clr_c),
        .en       (wd_en_c),
        .limit    (wd_limit_c),
        .expire_c (wd_exp_c)
    );

    // Sequencer FSM; every output is registered and set on entry to the state it belongs to.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state         <= S_IDLE;
            idx           <= '0;
            count         <= '0;
            bus.OP_ADDR   <= '0;
            bus.DUT_RST   <= 1'b1;
            bus.DUT_BEGIN <= 1'b0;
            bus.DUT_T     <= '0;
            bus.RES_WE    <= 1'b0;
            bus.RES_ADDR  <= '0;
            bus.RES_DATA  <= '0;
            BUSY          <= 1'b0;
            DONE          <= 1'b0;
            ABORTED       <= 1'b0;
            OF_CNT        <= '0;
            UF_CNT        <= '0;
            TO_CNT        <= '0;
        end else begin
            bus.DUT_BEGIN <= 1'b0;
            bus.RES_WE    <= 1'b0;
            DONE          <= 1'b0;

            if (abort_c) begin
                // Abort overrides ACK, timeout and write completion.
                state       <= S_DONE;
                DONE        <= 1'b1;
                BUSY        <= 1'b0;
                ABORTED     <= 1'b1;
                bus.DUT_RST <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (START) begin
                            count   <= n_clamp_c;
                            idx     <= '0;
                            OF_CNT  <= '0;
                            UF_CNT  <= '0;
                            TO_CNT  <= '0;
                            ABORTED <= 1'b0;
                            if (n_clamp_c == '0) begin
                                state <= S_DONE;
                                DONE  <= 1'b1;
                            end else begin
                                state <= S_URST;
                                BUSY  <= 1'b1;
                            end
                        end
                    end
                    S_URST: begin
                        if (wd_exp_c) begin
                            state       <= S_FETCH;
                            bus.DUT_RST <= 1'b0;
                            bus.OP_ADDR <= idx;
                        end
                    end
                    S_FETCH: begin
                        state <= S_LOAD;
                    end
                    S_LOAD: begin
                        state         <= S_BEGIN;
                        bus.DUT_T     <= bus.OP_DATA;
                        bus.DUT_BEGIN <= 1'b1;
                    end
                    S_BEGIN: begin
                        state <= S_WAIT_ACK;
                    end
                    S_WAIT_ACK: begin
                        if (bus.DUT_ACK) begin
                            state        <= S_WRITE;
                            bus.RES_WE   <= 1'b1;
                            bus.RES_ADDR <= idx;
                            bus.RES_DATA <= ack_word_c;
                            OF_CNT       <= OF_CNT + CW'(bus.DUT_OF);
                            UF_CNT       <= UF_CNT + CW'(bus.DUT_UF);
                        end else if (wd_exp_c) begin
                            state        <= S_WRITE;
                            bus.RES_WE   <= 1'b1;
                            bus.RES_ADDR <= idx;
                            bus.RES_DATA <= to_word_c;
                            TO_CNT       <= TO_CNT + CW'(1);
                        end
                    end
                    S_WRITE: begin
                        bus.DUT_RST <= 1'b1;
                        if (last_c) begin
                            state <= S_DONE;
                            DONE  <= 1'b1;
                            BUSY  <= 1'b0;
                        end else begin
                            state <= S_URST;
                            idx   <= idx + AW'(1);
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                        idx   <= '0;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Directed bench for fpu_op_sequencer with a scoreboard of expected result writes.
module tb_fpu_op_sequencer;
    localparam int unsigned P       = 32;
    localparam int unsigned DEPTH   = 8;
    localparam int unsigned RST_CYC = 4;
    localparam int unsigned TIMEOUT = 20;
    localparam int unsigned AW      = 3;
    localparam int unsigned CW      = AW + 1;
    localparam int unsigned RW      = P + 3;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [RW-1:0] data;
    } wr_t;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          START;
    logic          ABORT;
    logic [CW-1:0] N_OPS;
    logic          BUSY;
    logic          DONE;
    logic          ABORTED;
    logic [CW-1:0] OF_CNT;
    logic [CW-1:0] UF_CNT;
    logic [CW-1:0] TO_CNT;

    fpu_op_sequencer_if #(.P(P), .AW(AW)) bus ();

    fpu_op_sequencer #(
        .P       (P),
        .DEPTH   (DEPTH),
        .RST_CYC (RST_CYC),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .START   (START),
        .ABORT   (ABORT),
        .N_OPS   (N_OPS),
        .bus     (bus.master),
        .BUSY    (BUSY),
        .DONE    (DONE),
        .ABORTED (ABORTED),
        .OF_CNT  (OF_CNT),
        .UF_CNT  (UF_CNT),
        .TO_CNT  (TO_CNT)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int t0 = 0;
    int n_writes = 0;
    int n_done = 0;
    int wr_cyc [32];
    wr_t sb [$];

    logic [P-1:0] op_mem [DEPTH];
    int           ack_dly [DEPTH];   // WAIT_ACK cycle on which ACK is seen; 0 = never
    logic [DEPTH-1:0] of_mask;
    logic [DEPTH-1:0] uf_mask;

    int begin_cnt = 0;
    int op_no = 0;
    int wcnt = 0;
    bit waiting = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [RW-1:0] exp_word(input int i);
        if (ack_dly[i] == 0 || ack_dly[i] > int'(TIMEOUT))
            return {1'b1, 1'b0, 1'b0, {P{1'b0}}};
        return {1'b0, of_mask[i], uf_mask[i], op_mem[i] + P'(1)};
    endfunction

    always @(posedge CLK) cyc <= cyc + 1;

    // Sync-read operand memory.
    always @(posedge CLK) bus.OP_DATA <= op_mem[bus.OP_ADDR];

    // Unit model: ACK on a programmed WAIT_ACK cycle, RESULT = T + 1, flags from masks.
    always @(negedge CLK) begin
        if (bus.DUT_RST === 1'b1) begin
            waiting = 1'b0;
        end else if (bus.DUT_BEGIN === 1'b1) begin
            waiting = 1'b1;
            wcnt = 0;
            op_no = begin_cnt % int'(DEPTH);
            begin_cnt++;
        end else if (waiting) begin
            wcnt++;
        end
        bus.DUT_ACK    = waiting && (ack_dly[op_no] != 0) && (wcnt == ack_dly[op_no]);
        bus.DUT_OF     = of_mask[op_no];
        bus.DUT_UF     = uf_mask[op_no];
        bus.DUT_RESULT = bus.DUT_T + P'(1);
    end

    // Result-write monitor against the scoreboard, plus DONE pulse counting.
    always @(negedge CLK) begin
        wr_t e;
        if (bus.RES_WE === 1'b1) begin
            if (n_writes < 32) wr_cyc[n_writes] = cyc;
            n_writes++;
            chk("sb_has_entry", 64'(sb.size() != 0), 64'(1));
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("res_addr", 64'(bus.RES_ADDR), 64'(e.addr));
                chk("res_data", 64'(bus.RES_DATA), 64'(e.data));
            end
        end
        if (DONE === 1'b1) n_done++;
    end

    task automatic start_run(input int n, input int n_exp);
        for (int i = 0; i < n_exp; i++) sb.push_back('{addr: AW'(i), data: exp_word(i)});
        begin_cnt = 0;
        n_writes  = 0;
        n_done    = 0;
        @(negedge CLK);
        START = 1'b1;
        N_OPS = CW'(n);
        @(negedge CLK);
        START = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (DONE !== 1'b1 && k < budget) begin
            @(negedge CLK);
            k++;
        end
        chk("done_seen", 64'(DONE === 1'b1), 64'(1));
        @(negedge CLK);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        START = 1'b0;
        ABORT = 1'b0;
        N_OPS = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            op_mem[i]  = P'(32'h0000_1000 * (i + 1) + i);
            ack_dly[i] = 10;
        end
        of_mask = '0;
        uf_mask = '0;

        // Reset state
        repeat (3) @(negedge CLK);
        chk("rst_dut_rst", 64'(bus.DUT_RST), 64'(1));
        chk("rst_busy", 64'(BUSY), 64'(0));
        chk("rst_res_we", 64'(bus.RES_WE), 64'(0));
        chk("rst_cnts", 64'({OF_CNT, UF_CNT, TO_CNT}), 64'(0));
        RST = 1'b0;
        repeat (6) @(negedge CLK);
        chk("idle_dut_rst", 64'(bus.DUT_RST), 64'(1));
        chk("idle_busy", 64'(BUSY), 64'(0));
        chk("idle_no_writes", 64'(n_writes), 64'(0));

        // Three operands, ACK after 10 wait cycles, OF on operand 1
        of_mask = 8'b0000_0010;
        start_run(3, 3);
        chk("t2_busy", 64'(BUSY), 64'(1));
        wait_done(200);
        chk("t2_writes", 64'(n_writes), 64'(3));
        chk("t2_sb_empty", 64'(sb.size()), 64'(0));
        chk("t2_done_pulses", 64'(n_done), 64'(1));
        chk("t2_of_cnt", 64'(OF_CNT), 64'(1));
        chk("t2_uf_to_cnt", 64'({UF_CNT, TO_CNT}), 64'(0));
        chk("t2_busy_end", 64'(BUSY), 64'(0));
        chk("t2_first_lat", 64'(wr_cyc[0] - t0), 64'(RST_CYC + 3 + 10));
        chk("t2_gap01", 64'(wr_cyc[1] - wr_cyc[0]), 64'(18));
        chk("t2_gap12", 64'(wr_cyc[2] - wr_cyc[1]), 64'(18));

        // Operand 0 times out, operand 1 normal
        of_mask = '0;
        ack_dly[0] = 0;
        start_run(2, 2);
        wait_done(200);
        chk("t3_writes", 64'(n_writes), 64'(2));
        chk("t3_sb_empty", 64'(sb.size()), 64'(0));
        chk("t3_to_cnt", 64'(TO_CNT), 64'(1));
        chk("t3_of_cnt", 64'(OF_CNT), 64'(0));
        chk("t3_to_lat", 64'(wr_cyc[0] - t0), 64'(RST_CYC + 3 + TIMEOUT));
        chk("t3_gap01", 64'(wr_cyc[1] - wr_cyc[0]), 64'(RST_CYC + 3 + 10 + 1));
        ack_dly[0] = 10;

        // Abort on the second cycle of operand 1's WAIT_ACK
        start_run(4, 1);
        repeat (26) @(negedge CLK);
        ABORT = 1'b1;
        @(negedge CLK);
        ABORT = 1'b0;
        chk("t4_done", 64'(DONE), 64'(1));
        chk("t4_aborted", 64'(ABORTED), 64'(1));
        chk("t4_busy", 64'(BUSY), 64'(0));
        chk("t4_dut_rst", 64'(bus.DUT_RST), 64'(1));
        repeat (3) @(negedge CLK);
        chk("t4_writes", 64'(n_writes), 64'(1));
        chk("t4_sb_empty", 64'(sb.size()), 64'(0));
        chk("t4_done_pulses", 64'(n_done), 64'(1));
        chk("t4_aborted_sticky", 64'(ABORTED), 64'(1));

        // N_OPS = 0: DONE one cycle after START, ABORTED cleared, no writes
        start_run(0, 0);
        chk("t5a_done", 64'(DONE), 64'(1));
        chk("t5a_aborted_clr", 64'(ABORTED), 64'(0));
        chk("t5a_busy", 64'(BUSY), 64'(0));
        repeat (3) @(negedge CLK);
        chk("t5a_writes", 64'(n_writes), 64'(0));
        chk("t5a_done_pulses", 64'(n_done), 64'(1));

        // N_OPS = DEPTH+5 clamps to DEPTH operands; UF on operand 3
        for (int i = 0; i < int'(DEPTH); i++) ack_dly[i] = 1;
        uf_mask = 8'b0000_1000;
        start_run(int'(DEPTH) + 5, int'(DEPTH));
        wait_done(400);
        chk("t5b_writes", 64'(n_writes), 64'(DEPTH));
        chk("t5b_sb_empty", 64'(sb.size()), 64'(0));
        chk("t5b_uf_cnt", 64'(UF_CNT), 64'(1));
        chk("t5b_to_cnt", 64'(TO_CNT), 64'(0));
        uf_mask = '0;

        // ACK on the exact timeout cycle wins over the timeout
        ack_dly[0] = int'(TIMEOUT);
        start_run(1, 1);
        wait_done(200);
        chk("t5c_writes", 64'(n_writes), 64'(1));
        chk("t5c_to_cnt", 64'(TO_CNT), 64'(0));
        chk("t5c_lat", 64'(wr_cyc[0] - t0), 64'(RST_CYC + 3 + TIMEOUT));

        // Async reset during WAIT_ACK, then a clean run from index 0
        for (int i = 0; i < int'(DEPTH); i++) ack_dly[i] = 10;
        start_run(2, 2);
        repeat (9) @(negedge CLK);
        RST = 1'b1;
        #1;
        chk("t6_dut_rst", 64'(bus.DUT_RST), 64'(1));
        chk("t6_busy", 64'(BUSY), 64'(0));
        chk("t6_dut_t", 64'(bus.DUT_T), 64'(0));
        chk("t6_begin_we", 64'({bus.DUT_BEGIN, bus.RES_WE}), 64'(0));
        sb.delete();
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        start_run(2, 2);
        wait_done(200);
        chk("t6_writes", 64'(n_writes), 64'(2));
        chk("t6_sb_empty", 64'(sb.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
